hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath; sequences the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates load-use stalls, taken-branch flushes and full-pipeline freezes while data memory is busy.
- Detects memory-wait timeouts.
- Pipeline registers capture on the falling edge of clock; this block updates state on the rising edge, so its combinational outputs settle half a cycle before capture.

Parameters:
- FLUSH_EXTRA, 0: additional cycles if_id_flush stays high after a taken branch (0..15).
- MAX_WAIT, 64: consecutive memory-wait cycles before timeout (2..65535).
- CNT_W, 16: width of the performance counters (optional feature).

Ports:
- clock  in  1  system clock; rising edge updates state.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- ex_rt  in  5  rt destination of the instruction in EX (ID/EX rt output).
- ex_MemRead  in  1  instruction in EX is a load.
- branch_taken  in  1  branch resolved taken in MEM this cycle.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory access completes this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  zero the IF/ID instruction.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  load zeros into ID/EX control fields.
- ex_mem_write  out  1  EX/MEM load enable.
- ex_mem_flush  out  1  zero the EX/MEM control fields.
- mem_wb_bubble  out  1  load zeros into MEM/WB control fields.
- timeout_err  out  1  sticky memory timeout flag.
- state_out  out  2  current FSM state.

Behaviour:
- State encoding: RUN=0, FLUSH=1, MEM_WAIT=2, TIMEOUT=3.
- Default output values: all *_write=1, all flush/bubble=0.
- Outputs are combinational from the current state and inputs.
- Reset (while high): pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, mem_wb_bubble=1, id_ex_write=1, ex_mem_write=1.
- Next state after reset: RUN, wait_cnt=0, flush_cnt=0, timeout_err=0. Reset overrides every state, including TIMEOUT and mid-wait.
- Load-use hazard definition: lu = ex_MemRead & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
- Evaluation in RUN, highest priority first:
  1. mem_req & !mem_ready: freeze. pc_write, if_id_write, id_ex_write and ex_mem_write = 0; mem_wb_bubble=1. Go to MEM_WAIT, wait_cnt=1. A branch_taken asserted in this cycle is ignored; the MEM stage re-presents it after the wait.
  2. branch_taken: if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; pc_write=1 (target loads). If FLUSH_EXTRA>0, go to FLUSH with flush_cnt=FLUSH_EXTRA, else stay in RUN. A simultaneous lu is ignored because the flush kills it.
  3. lu: pc_write=0, if_id_write=0, id_ex_bubble=1. Stay in RUN; exactly one bubble per hazard, since ex_MemRead is low on the next cycle.
- FLUSH: if_id_flush=1 and flush_cnt decrements; leave for RUN when flush_cnt reaches 1. Memory freeze takes priority over FLUSH: move to MEM_WAIT, and the remaining flush is abandoned.
- MEM_WAIT:
  - While mem_ready=0: freeze outputs as above, wait_cnt increments.
  - If wait_cnt==MAX_WAIT with mem_ready=0: go to TIMEOUT.
  - When mem_ready=1: outputs and next state are evaluated exactly as in RUN, ignoring rule 1; wait_cnt is cleared.
- TIMEOUT: permanent freeze (same outputs as MEM_WAIT); timeout_err=1. Only reset exits this state.
- The wait counter saturates and never wraps.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[CNT_W] and flush_events[CNT_W], both cleared by reset.
  - stall_cycles increments each cycle pc_write=0 outside reset.
  - flush_events increments on each accepted branch_taken.
  - Both saturate at all-ones.
- Not defined: these ports and counters do not exist.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> during reset pc_write=0 and if_id_flush=1; afterwards state_out=0 and all *_write=1.
- ex_MemRead=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle only. Repeat with ex_rt=0 -> no stall.
- branch_taken pulse with FLUSH_EXTRA=2 -> flush outputs high on cycle 0; if_id_flush stays high for 2 more cycles; state FLUSH, then RUN.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all writes 0 for 3 cycles, normal on the 4th; state_out 2 then 0.
- mem_req=1, mem_ready=0 held with MAX_WAIT=4 -> TIMEOUT after 4 wait cycles, timeout_err=1 until reset pulse clears it.
- branch_taken and lu in the same cycle; then branch_taken during MEM_WAIT -> flush only (no stall); the branch is ignored until mem_ready.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM hazard inputs and pipeline-register control outputs.
// The master side is the datapath. The slave side is hazard_ctrl.
interface hazard_ctrl_if;
    localparam int unsigned REG_W = 5;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_rt;
    logic             ex_MemRead;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             ex_mem_flush;
    logic             mem_wb_bubble;
    logic             timeout_err;
    logic [1:0]       state_out;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_MemRead, branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, ex_mem_flush, mem_wb_bubble, timeout_err, state_out
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_MemRead, branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, ex_mem_flush, mem_wb_bubble, timeout_err, state_out
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freezes and wait timeout.
// Defining HAZARD_PERF_CNT_EN adds the saturating stall_cycles / flush_events counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_EXTRA = 0,
    parameter int unsigned MAX_WAIT    = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    hazard_ctrl_if.slave     bus
);
    localparam int unsigned WAIT_W  = 16;
    localparam int unsigned FLUSH_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        TIMEOUT  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [WAIT_W-1:0]    wait_nxt;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic [FLUSH_W-1:0]   flush_nxt;
    logic                 timeout_err;

    logic                 lu;
    logic                 freeze;
    logic                 run_eval;
    logic                 branch_acc;

    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_write;
    logic                 id_ex_bubble;
    logic                 ex_mem_write;
    logic                 ex_mem_flush;
    logic                 mem_wb_bubble;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    assign lu = bus.ex_MemRead && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            flush_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            flush_cnt   <= flush_nxt;
            timeout_err <= timeout_err || (state_nxt == TIMEOUT);
        end
    end

    // Next-state and combinational pipeline controls; outputs settle before the falling-edge capture.
    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        flush_nxt     = flush_cnt;
        freeze        = 1'b0;
        run_eval      = 1'b0;
        branch_acc    = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;

        case (state)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
            FLUSH: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                    flush_nxt = '0;
                end else begin
                    if_id_flush = 1'b1;
                    if (flush_cnt <= FLUSH_W'(1)) begin
                        state_nxt = RUN;
                        flush_nxt = '0;
                    end else begin
                        flush_nxt = flush_cnt - FLUSH_W'(1);
                    end
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    freeze = 1'b1;
                    if (wait_cnt >= WAIT_W'(MAX_WAIT)) begin
                        state_nxt = TIMEOUT;
                    end else if (wait_cnt != {WAIT_W{1'b1}}) begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    run_eval  = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            TIMEOUT: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Branch outranks load-use: the flush removes the stalled instruction anyway.
        if (run_eval) begin
            if (bus.branch_taken) begin
                branch_acc   = 1'b1;
                pc_write     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
                if (FLUSH_EXTRA > 0) begin
                    state_nxt = FLUSH;
                    flush_nxt = FLUSH_W'(FLUSH_EXTRA);
                end
            end else if (lu) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end

        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end

        // While reset is high, the pipeline is held empty, whatever the state.
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_wb_bubble = 1'b1;
            branch_acc    = 1'b0;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.if_id_write   = if_id_write;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_write   = id_ex_write;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.ex_mem_write  = ex_mem_write;
    assign bus.ex_mem_flush  = ex_mem_flush;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.timeout_err   = timeout_err;
    assign bus.state_out     = state;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (branch_acc && (flush_events != {CNT_W{1'b1}})) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = ^{branch_acc, CNT_W[0]};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver queues the expected controls for each vector,
// and a monitor compares them on the falling edge.
module tb_hazard_ctrl;
    localparam int unsigned FLUSH_EXTRA = 2;
    localparam int unsigned MAX_WAIT    = 4;
    localparam int unsigned CNT_W       = 16;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_bubble}
    localparam logic [7:0] RST = 8'b0011_1111;
    localparam logic [7:0] NRM = 8'b1101_0100;
    localparam logic [7:0] STL = 8'b0001_1100;
    localparam logic [7:0] BRN = 8'b1111_1110;
    localparam logic [7:0] FLS = 8'b1111_0100;
    localparam logic [7:0] FRZ = 8'b0000_0001;

    typedef struct packed {
        int         idx;
        logic [7:0] ctl;
        logic       tmo;
        logic [1:0] st;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   nvec   = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    always #5 clock = ~clock;

    hazard_ctrl_if hif();

    hazard_ctrl #(
        .FLUSH_EXTRA(FLUSH_EXTRA),
        .MAX_WAIT   (MAX_WAIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles),
        .flush_events(flush_events),
`endif
        .bus         (hif)
    );

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s vec%0d: got %0h want %0h", nm, idx, act, exp);
    endtask

    task automatic vec(input logic rst, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic [4:0] ert, input logic mr, input logic br, input logic rq,
                       input logic rd, input logic [7:0] ctl, input logic [1:0] st, input logic tmo);
        @(posedge clock);
        #1;
        reset            = rst;
        hif.id_rs        = rs;
        hif.id_rt        = rt;
        hif.id_uses_rt   = ur;
        hif.ex_rt        = ert;
        hif.ex_MemRead   = mr;
        hif.branch_taken = br;
        hif.mem_req      = rq;
        hif.mem_ready    = rd;
        nvec++;
        q.push_back('{idx: nvec, ctl: ctl, tmo: tmo, st: st});
    endtask

    // Monitor: the outputs are valid every cycle, so one queued expectation is consumed per falling edge.
    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_write,
                       hif.id_ex_bubble, hif.ex_mem_write, hif.ex_mem_flush, hif.mem_wb_bubble};
                check("ctl",   e.idx, 32'(got),             32'(e.ctl));
                check("state", e.idx, 32'(hif.state_out),   32'(e.st));
                check("tmo",   e.idx, 32'(hif.timeout_err), 32'(e.tmo));
            end
        end
    end

    initial begin
        reset            = 1'b1;
        hif.id_rs        = '0;
        hif.id_rt        = '0;
        hif.id_uses_rt   = 1'b0;
        hif.ex_rt        = '0;
        hif.ex_MemRead   = 1'b0;
        hif.branch_taken = 1'b0;
        hif.mem_req      = 1'b0;
        hif.mem_ready    = 1'b0;

        //   rst rs    rt    ur  ert   mr br rq rd  ctl  st tmo
        vec(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, RST, 0, 0);  // reset held
        vec(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, RST, 0, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0, 0);
        vec(0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, STL, 0, 0);  // load-use on rs
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, NRM, 0, 0);  // ex_rt = 0: no hazard
        vec(0, 5'd3, 5'd7, 1, 5'd7, 1, 0, 0, 0, STL, 0, 0);  // load-use on rt
        vec(0, 5'd3, 5'd7, 0, 5'd7, 1, 0, 0, 0, NRM, 0, 0);  // rt not a source
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, BRN, 0, 0);  // taken branch
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, FLS, 1, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, FLS, 1, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 0);  // memory wait x3
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, NRM, 2, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0, 0);
        vec(0, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0, BRN, 0, 0);  // branch + load-use: flush only
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, FLS, 1, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, FLS, 1, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, FRZ, 2, 0);  // branch ignored while waiting
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1, BRN, 2, 0);  // re-presented on ready
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1, 0);  // freeze beats FLUSH
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2, 0);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2, 0);  // wait_cnt == MAX_WAIT
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 3, 1);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, FRZ, 3, 1);  // only reset leaves TIMEOUT
        vec(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, RST, 3, 1);
        vec(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NRM, 0, 0);

        repeat (3) @(posedge clock);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending want 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
